// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron block and its host-side Q loader.
package neuron_pkg;

    localparam int Q_ADDR_WIDTH = 10;
    localparam int Q_DATA_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } q_load_state_t;

    function automatic int entries_per_word(input int host_w, input int q_w);
        return host_w / q_w;
    endfunction

endpackage

// File: rtl/neuron_q_loader_if.sv
// Host word stream into the Q loader.
// A word transfers on a rising edge where host_valid && host_ready; host_data
// is only meaningful while host_valid is high, and ready never depends on valid.
interface neuron_q_loader_if #(
    parameter int HOST_DATA_WIDTH = 16
) ();

    logic                       host_valid;
    logic [HOST_DATA_WIDTH-1:0] host_data;
    logic                       host_ready;

    modport master (
        output host_valid,
        output host_data,
        input  host_ready
    );

    modport slave (
        input  host_valid,
        input  host_data,
        output host_ready
    );

endinterface

// File: rtl/neuron_q_loader.sv
// Unpacks host words into Q entries and streams them to the neuron's Q RAM
// through wrQ/Q_in, using a shift register plus a one-word prefetch buffer.
module neuron_q_loader #(
    parameter int Q_ADDR_WIDTH    = neuron_pkg::Q_ADDR_WIDTH,
    parameter int Q_DATA_WIDTH    = neuron_pkg::Q_DATA_WIDTH,
    parameter int HOST_DATA_WIDTH = 16,
    parameter int Q_DEPTH         = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    neuron_q_loader_if.slave            host,
    output logic                        wrQ,
    output logic [Q_DATA_WIDTH-1:0]     Q_in,
    output logic [Q_ADDR_WIDTH:0]       q_count,
    output logic                        busy,
    output logic                        done,
    output neuron_pkg::q_load_state_t   state_dbg
);

    import neuron_pkg::*;

    localparam int EPW = entries_per_word(HOST_DATA_WIDTH, Q_DATA_WIDTH);
    localparam int CW  = $clog2(EPW + 1);
    localparam int NW  = Q_ADDR_WIDTH + 1;

    q_load_state_t              state;
    logic [HOST_DATA_WIDTH-1:0] sh;
    logic [CW-1:0]              sh_cnt;
    logic [HOST_DATA_WIDTH-1:0] hold;
    logic [CW-1:0]              hold_cnt;
    logic                       hold_v;
    // Entries not yet credited to an accepted word; zero means no more words.
    logic [NW-1:0]              rem;

    logic                       accept;
    logic                       sh_drains;
    logic                       last_entry;
    logic [CW-1:0]              word_cnt;

    always_comb begin
        wrQ             = (state == LOAD) && (sh_cnt != '0);
        Q_in            = wrQ ? sh[Q_DATA_WIDTH-1:0] : '0;
        host.host_ready = (state == LOAD) && !hold_v && (rem != '0);
        busy            = (state != IDLE);
        done            = (state == FINISH);
        state_dbg       = state;
    end

    always_comb begin
        accept     = host.host_valid && host.host_ready;
        // sh is free at this edge if already empty or its last entry goes out now.
        sh_drains  = (sh_cnt == '0) || (wrQ && (sh_cnt == CW'(1)));
        last_entry = wrQ && (q_count == NW'(Q_DEPTH - 1));
        // The final word may carry surplus high entries that are never strobed.
        word_cnt   = (rem >= NW'(EPW)) ? CW'(EPW) : CW'(rem);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sh       <= '0;
            sh_cnt   <= '0;
            hold     <= '0;
            hold_cnt <= '0;
            hold_v   <= 1'b0;
            rem      <= '0;
            q_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        sh       <= '0;
                        sh_cnt   <= '0;
                        hold     <= '0;
                        hold_cnt <= '0;
                        hold_v   <= 1'b0;
                        rem      <= NW'(Q_DEPTH);
                        q_count  <= '0;
                    end
                end
                LOAD: begin
                    if (wrQ) begin
                        sh      <= sh >> Q_DATA_WIDTH;
                        sh_cnt  <= sh_cnt - CW'(1);
                        q_count <= q_count + NW'(1);
                    end
                    if (accept) begin
                        rem <= rem - NW'(word_cnt);
                    end
                    // Refill priority: held word first, then the incoming word.
                    if (sh_drains) begin
                        if (hold_v) begin
                            sh     <= hold;
                            sh_cnt <= hold_cnt;
                            hold_v <= 1'b0;
                        end else if (accept) begin
                            sh     <= host.host_data;
                            sh_cnt <= word_cnt;
                        end
                    end else if (accept) begin
                        hold     <= host.host_data;
                        hold_cnt <= word_cnt;
                        hold_v   <= 1'b1;
                    end
                    if (last_entry) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_q_loader.sv
// Randomized scoreboard bench for neuron_q_loader with a 45-entry load
// (six 8-entry words, the last one only partly used).
module tb_neuron_q_loader;

    localparam int AW  = 10;
    localparam int QW  = 2;
    localparam int HW  = 16;
    localparam int QD  = 45;
    localparam int EPW = HW / QW;
    localparam int WN  = (QD + EPW - 1) / EPW;

    logic                      clk;
    logic                      reset;
    logic                      start;
    logic                      wrQ;
    logic [QW-1:0]             Q_in;
    logic [AW:0]               q_count;
    logic                      busy;
    logic                      done;
    neuron_pkg::q_load_state_t state_dbg;

    neuron_q_loader_if #(.HOST_DATA_WIDTH(HW)) ifc ();

    neuron_q_loader #(
        .Q_ADDR_WIDTH   (AW),
        .Q_DATA_WIDTH   (QW),
        .HOST_DATA_WIDTH(HW),
        .Q_DEPTH        (QD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .host     (ifc.slave),
        .wrQ      (wrQ),
        .Q_in     (Q_in),
        .q_count  (q_count),
        .busy     (busy),
        .done     (done),
        .state_dbg(state_dbg)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    logic [QW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int wrq_cnt, first_wr, last_wr, max_gap, done_cnt, done_cyc, ready_late;
    bit all_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops one expected entry per wrQ cycle
    initial forever begin
        logic [QW-1:0] e;
        @(negedge clk);
        if (!reset) begin
            if (wrQ) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wrq", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("q_in", 32'(Q_in), 32'(e));
                end
                if (first_wr < 0) first_wr = cyc;
                else if (cyc - last_wr - 1 > max_gap) max_gap = cyc - last_wr - 1;
                last_wr = cyc;
                wrq_cnt++;
            end else if (busy) begin
                check("q_in_zero_when_idle", 32'(Q_in), 32'd0);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (all_acc && ifc.host_ready) ready_late++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: sustained i%3; 1: 20-cycle stall after word 2; 2: random gaps and
    // a stray start; 3: words 0xFFFF, 0x5555 first; 4: sustained, reset at abort_at
    task automatic run_load(input int mode, input int abort_at);
        logic [HW-1:0] words[WN];
        logic [QW-1:0] ent;
        int idx, accepted, t, g;
        bit aborted;
        for (int w = 0; w < WN; w++) begin
            for (int k = 0; k < EPW; k++) begin
                idx = w * EPW + k;
                if (mode == 0 || mode == 4) ent = QW'(idx % 3);
                else ent = QW'($urandom_range(0, 3));
                if (mode == 3 && w == 0) ent = 2'd3;
                if (mode == 3 && w == 1) ent = 2'd1;
                if (idx >= QD) ent = QW'($urandom_range(0, 3));
                words[w][k*QW +: QW] = ent;
                if (idx < QD) exp_q.push_back(ent);
            end
        end
        wrq_cnt = 0; first_wr = -1; last_wr = 0; max_gap = 0;
        done_cnt = 0; done_cyc = 0; ready_late = 0; all_acc = 0;
        accepted = 0; aborted = 0;

        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("ready_after_start", 32'(ifc.host_ready), 32'd1);
        check("q_count_cleared", 32'(q_count), 32'd0);

        for (int w = 0; w < WN && !aborted; w++) begin
            g = (mode == 2) ? int'($urandom_range(0, 12)) : ((mode == 1 && w == 2) ? 20 : 0);
            ifc.host_valid = 1'b0;
            ifc.host_data  = HW'($urandom);
            repeat (g) tick();
            if (mode == 2 && w == 3) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                check("q_count_ignores_start", 32'(q_count), 32'(wrq_cnt));
            end
            ifc.host_valid = 1'b1;
            ifc.host_data  = words[w];
            t = 0;
            while (!ifc.host_ready && t < 200 && !aborted) begin
                tick();
                t++;
                aborted = (abort_at > 0) && (wrq_cnt >= abort_at);
            end
            if (!aborted && t >= 200) begin
                check("handshake_timeout", 32'd1, 32'd0);
                aborted = 1;
            end
            if (!aborted) begin
                tick();
                accepted++;
                aborted = (abort_at > 0) && (wrq_cnt >= abort_at);
            end
        end
        ifc.host_valid = 1'b0;
        ifc.host_data  = HW'($urandom);

        if (abort_at > 0) begin
            while (wrq_cnt < abort_at && t < 400) begin
                tick();
                t++;
            end
            #1 reset = 1'b1;
            #1;
            check("reset_wrq", 32'(wrQ), 32'd0);
            check("reset_busy", 32'(busy), 32'd0);
            check("reset_q_count", 32'(q_count), 32'd0);
            check("reset_ready", 32'(ifc.host_ready), 32'd0);
            exp_q.delete();
            tick();
            reset = 1'b0;
            tick();
            return;
        end

        all_acc = (accepted == WN);
        t = 0;
        while (done_cnt == 0 && t < 400) begin
            tick();
            t++;
        end
        check("done_seen", 32'(done_cnt > 0), 32'd1);
        check("busy_clear_after_done", 32'(busy), 32'd0);
        check("q_count_final", 32'(q_count), 32'(QD));
        check("entries_left", 32'(exp_q.size()), 32'd0);
        check("wrq_cycles", 32'(wrq_cnt), 32'(QD));
        check("done_after_last_wrq", 32'(done_cyc), 32'(last_wr + 1));
        check("words_accepted", 32'(accepted), 32'(WN));
        if (mode == 0) check("contiguous_wrq", 32'(last_wr - first_wr + 1), 32'(QD));
        if (mode == 1) check("underrun_gap", 32'(max_gap >= 4), 32'd1);
        repeat (3) tick();
        check("done_single_pulse", 32'(done_cnt), 32'd1);
        check("q_count_holds", 32'(q_count), 32'(QD));
        check("ready_after_last_word", 32'(ready_late), 32'd0);
        all_acc = 0;
        exp_q.delete();
    endtask

    // Main sequence
    initial begin
        reset = 1'b1;
        start = 1'b0;
        ifc.host_valid = 1'b0;
        ifc.host_data  = '0;
        #12;
        check("rst_ready", 32'(ifc.host_ready), 32'd0);
        check("rst_wrq", 32'(wrQ), 32'd0);
        check("rst_q_in", 32'(Q_in), 32'd0);
        check("rst_q_count", 32'(q_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(neuron_pkg::IDLE));
        tick();
        reset = 1'b0;
        ifc.host_valid = 1'b1;
        ifc.host_data  = HW'($urandom);
        repeat (3) tick();
        check("idle_ignores_valid", 32'(ifc.host_ready), 32'd0);
        ifc.host_valid = 1'b0;

        run_load(0, 0);
        run_load(3, 0);
        run_load(1, 0);
        run_load(2, 0);
        run_load(4, 30);
        run_load(0, 0);
        for (int i = 0; i < 4; i++) run_load(2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
